// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration for a shared four-digit seven-segment display.
// Optional feature macro: SEG_ARB_OWNER_DOT_EN (dots show the owner index as one-hot).
module seg_display_arbiter #(
  parameter int n_req        = 3,
  parameter int w_digit      = 4,
  parameter int dwell_cycles = 25_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [n_req-1:0]           req,
  input  logic [n_req*4*w_digit-1:0] req_number,
  input  logic [n_req*w_digit-1:0]   req_dots,
  output logic [n_req-1:0]           grant,
  output logic [4*w_digit-1:0]       number,
  output logic [w_digit-1:0]         dots,
  output logic                       busy
);

  localparam int IW = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int CW = $clog2(dwell_cycles + 1);
  localparam int NW = 4 * w_digit;
  localparam logic [CW-1:0] DWELL = CW'(dwell_cycles);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]         state_reg, state_next;
  logic [IW-1:0]      own_reg, own_next;
  logic [IW-1:0]      last_reg, last_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [n_req-1:0]   grant_reg;
  logic [NW-1:0]      number_reg;
  logic [w_digit-1:0] dots_reg;
  logic               busy_reg;

  logic [NW-1:0]      num_arr [n_req];
  logic [w_digit-1:0] dot_arr [n_req];
  logic [n_req-1:0]   own_hot, own_next_hot, cand;
  logic               owner_req, win_found;
  logic [IW-1:0]      win_idx;
  int                 scan_idx;

  generate
    for (genvar gi = 0; gi < n_req; gi++) begin : g_slice
      assign num_arr[gi]      = req_number[gi*NW +: NW];
      assign dot_arr[gi]      = req_dots[gi*w_digit +: w_digit];
      assign own_hot[gi]      = (own_reg == IW'(gi));
      assign own_next_hot[gi] = (own_next == IW'(gi));
    end
  endgenerate

`ifdef SEG_ARB_OWNER_DOT_EN
  generate
    if (n_req > w_digit) begin : g_dot_check
      $error("seg_display_arbiter: owner dots need n_req <= w_digit");
    end
  endgenerate
`endif

  // While holding, the owner is excluded so a contended hand-over always moves on.
  assign owner_req = |(req & own_hot);
  assign cand      = (state_reg == HOLD) ? (req & ~own_hot) : req;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 1; k <= n_req; k++) begin
      scan_idx = (int'(last_reg) + k) % n_req;
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    own_next   = own_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = HOLD;
          own_next   = win_idx;
          last_next  = win_idx;
          cnt_next   = '0;
        end
      end
      HOLD: begin
        if (owner_req) begin
          if (cnt_reg == DWELL && win_found) begin
            own_next  = win_idx;
            last_next = win_idx;
            cnt_next  = '0;
          end else if (cnt_reg != DWELL) begin
            cnt_next = cnt_reg + CW'(1);
          end
        end else if (win_found) begin
          own_next  = win_idx;
          last_next = win_idx;
          cnt_next  = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      own_reg    <= '0;
      last_reg   <= IW'(n_req - 1);
      cnt_reg    <= '0;
      grant_reg  <= '0;
      number_reg <= '0;
      dots_reg   <= '0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      own_reg   <= own_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      if (state_next == HOLD) begin
        // Reloaded every cycle so the owner's live data shows one cycle later.
        grant_reg  <= own_next_hot;
        number_reg <= num_arr[own_next];
`ifdef SEG_ARB_OWNER_DOT_EN
        dots_reg   <= w_digit'(own_next_hot);
`else
        dots_reg   <= dot_arr[own_next];
`endif
        busy_reg   <= 1'b1;
      end else begin
        grant_reg <= '0;
        busy_reg  <= 1'b0;
`ifdef SEG_ARB_OWNER_DOT_EN
        dots_reg  <= '0;
`endif
      end
    end
  end

  assign grant  = grant_reg;
  assign number = number_reg;
  assign dots   = dots_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed-vector bench for seg_display_arbiter (n_req=3, w_digit=4, dwell_cycles=4).
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [47:0] req_number;
  logic [11:0] req_dots;
  logic [2:0]  grant;
  logic [15:0] number;
  logic [3:0]  dots;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  seg_display_arbiter #(.n_req(3), .w_digit(4), .dwell_cycles(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_number(req_number), .req_dots(req_dots),
    .grant(grant), .number(number), .dots(dots), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one clock edge; samples taken afterwards sit 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] g, input logic [15:0] n,
                            input logic [3:0] d, input logic b);
    check({tag, ".grant"},  32'(grant),  32'(g));
    check({tag, ".number"}, 32'(number), 32'(n));
    check({tag, ".dots"},   32'(dots),   32'(d));
    check({tag, ".busy"},   32'(busy),   32'(b));
  endtask

  logic [2:0] exp_g;

  initial begin
    rst        = 1'b1;
    req        = 3'b000;
    req_number = {16'h3333, 16'hBEEF, 16'h1111};
    req_dots   = {4'h4, 4'hA, 4'h1};
    tick(); tick(); tick();
    check_outs("reset", 3'b000, 16'h0000, 4'h0, 1'b0);

    // Single requester, then drop to IDLE with the value retained.
    rst = 1'b0;
    req = 3'b010;
    tick();
    check_outs("single", 3'b010, 16'hBEEF, 4'hA, 1'b1);
    req = 3'b000;
    tick();
    check_outs("drop_idle", 3'b000, 16'hBEEF, 4'hA, 1'b0);

    // Continuous contention from reset: each owner holds exactly 5 cycles.
    req_number = {16'h3333, 16'h2222, 16'h1111};
    rst = 1'b1;
    req = 3'b111;
    tick();
    rst = 1'b0;
    tick();
    for (int g = 0; g < 4; g++) begin
      exp_g = 3'b001 << (g % 3);
      for (int c = 0; c < 5; c++) begin
        check($sformatf("rot%0d.c%0d.grant", g, c), 32'(grant), 32'(exp_g));
        if (c == 0)
          check($sformatf("rot%0d.number", g), 32'(number),
                32'((g % 3 == 0) ? 16'h1111 : (g % 3 == 1) ? 16'h2222 : 16'h3333));
        tick();
      end
    end

    // Early drop at cnt=1 while requester 2 waits; the new owner starts a fresh dwell.
    rst = 1'b1;
    req = 3'b101;
    tick();
    rst = 1'b0;
    tick();
    check("early.grant0", 32'(grant), 32'(3'b001));
    tick();
    req = 3'b100;
    tick();
    check_outs("early.switch", 3'b100, 16'h3333, 4'h4, 1'b1);
    req = 3'b101;
    for (int c = 1; c < 5; c++) begin
      tick();
      check($sformatf("early.hold%0d", c), 32'(grant), 32'(3'b100));
    end
    tick();
    check("early.handover", 32'(grant), 32'(3'b001));

    // Live data update from the owner with no grant change.
    rst = 1'b1;
    req = 3'b010;
    req_number = {16'h3333, 16'h1234, 16'h1111};
    tick();
    rst = 1'b0;
    tick();
    check_outs("live.before", 3'b010, 16'h1234, 4'hA, 1'b1);
    req_number = {16'h3333, 16'h5678, 16'h1111};
    req_dots   = {4'h4, 4'h5, 4'h1};
    tick();
    check_outs("live.after", 3'b010, 16'h5678, 4'h5, 1'b1);

    // Reset mid-HOLD (cnt=2) clears everything and restores the pointer.
    tick();
    rst = 1'b1;
    tick();
    check_outs("rst_mid", 3'b000, 16'h0000, 4'h0, 1'b0);
    rst = 1'b0;
    req = 3'b111;
    tick();
    check_outs("rst_mid.restart", 3'b001, 16'h1111, 4'h1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
